// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding, parity-mode codes
// and the oversampling ratio used to time each bit on the line.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE3 = 2'b11;

  // sam_tick pulses per serial bit
  localparam int TICKS_PER_BIT = 16;

  // A parity bit is only sent for the odd and even modes; 00 and 11 both mean none
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO that buffers bytes ahead of the UART transmitter.
// DEPTH must be a power of two (at least 2) so the pointers wrap on their own.
// A push is taken while full as long as a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == COUNT_FULL);
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Qualify requests and advance pointers / occupancy
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written at the write pointer
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits, each bit held for TICKS_PER_BIT sam_tick pulses.
// Build option UART_TX_FIFO_EN places a FIFO_DEPTH-entry buffer (uart_tx_fifo)
// in front of the FSM; without it the FSM takes bytes directly in IDLE.
//
// Handshake: a byte on data_in is taken on a rising clk edge where tx_start
// and tx_ready are both high; tx_start while tx_ready is low is dropped.
// Parity mode and stop-bit count are captured when the FSM loads the byte.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sam_tick,
  input  logic [1:0]        parity,
  input  logic              stop_bit,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] data_in,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done,
  output tx_state_e         dbg_state
);
  localparam int               BIT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [4:0]       TICK_LAST_1 = 5'(TICKS_PER_BIT - 1);
  localparam logic [4:0]       TICK_LAST_2 = 5'(2 * TICKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [4:0]        tick_q, tick_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;

`ifdef UART_TX_FIFO_EN
  logic fifo_full, fifo_empty, fifo_pop, fifo_push;

  assign tx_ready   = !fifo_full;
  assign fifo_push  = tx_start && tx_ready;
  assign fifo_pop   = (state_q == IDLE) && !fifo_empty;
  assign load_valid = fifo_pop;

  uart_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (data_in),
    .pop     (fifo_pop),
    .rd_data (load_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
`else
  logic unused_fifo_depth;

  assign unused_fifo_depth = ^FIFO_DEPTH;
  assign tx_ready          = (state_q == IDLE);
  assign load_valid        = tx_start && tx_ready;
  assign load_data         = data_in;
`endif

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign tx_done   = done_q;
  assign dbg_state = state_q;

  // Next-state, tick/bit counting and the registered line value
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;

    // The second stop bit is folded into one 32-tick STOP period
    bit_end = sam_tick &&
              (tick_q == (((state_q == STOP) && stop2_q) ? TICK_LAST_2 : TICK_LAST_1));

    if ((state_q != IDLE) && sam_tick) begin
      tick_d = bit_end ? 5'd0 : tick_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d   = START;
          shift_d   = load_data;
          par_en_d  = parity_enabled(parity);
          par_bit_d = (parity == PAR_ODD) ? ~(^load_data) : (^load_data);
          stop2_d   = stop_bit;
          tick_d    = 5'd0;
          bit_d     = '0;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the state being entered so the line never glitches
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_d;
      default: tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame with the line idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm. Frames are decoded off the serial line by a monitor
// and compared against hand-computed frame words pushed by the stimulus.
// Frame word: [15:12] number of bit periods seen before tx_done,
// [11:0] line value of each period, bit 0 = start bit.
`timescale 1ns/1ps
module tb_uart_tx_fsm;
  import uart_pkg::*;

  localparam int W = 16;

  logic       clk;
  logic       reset;
  logic       sam_tick;
  logic [1:0] parity;
  logic       stop_bit;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;
  tx_state_e  dbg_state;

  logic [W-1:0] exp_q[$];
  int total    = 0;
  int bad      = 0;
  int done_cnt = 0;
  int pushes   = 0;
  logic prev_done;

  uart_tx_fsm #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sam_tick  (sam_tick),
    .parity    (parity),
    .stop_bit  (stop_bit),
    .tx_start  (tx_start),
    .data_in   (data_in),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done),
    .dbg_state (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // sam_tick on every third clk, so idle clks sit between ticks
  initial begin
    sam_tick = 1'b0;
    forever begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk);
        #1;
        sam_tick = (k == 0);
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  // Wait for tx_ready, optionally queue the expected frame, strobe one byte
  task automatic send(input logic [7:0] d, input logic [1:0] p, input logic s,
                      input logic do_push, input logic [W-1:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_wait: tx_ready=%b want 1", tx_ready);
    end
    if (do_push) begin
      exp_q.push_back(w);
      pushes++;
    end
    data_in  = d;
    parity   = p;
    stop_bit = s;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
  endtask

  // Returns on the negedge where tx_done is high
  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (tx_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (tx_done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_wait: tx_done=%b want 1", tx_done);
    end
  endtask

  // tx_done counter; each pulse must be exactly one clk wide
  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) begin
        done_cnt++;
        check1("done_width", prev_done, 1'b0);
      end
      prev_done = tx_done;
    end
  end

  // Monitor: decode each frame from the line and score it
  initial begin : monitor
    logic [11:0]  bits;
    int           nb;
    int           ticks;
    logic         bv;
    logic         glitch;
    logic         aborted;
    logic         fin;
    logic [W-1:0] act;
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      if (reset === 1'b0 && tx === 1'b0) begin
        bits    = '0;
        nb      = 0;
        glitch  = 1'b0;
        aborted = 1'b0;
        fin     = 1'b0;
        while (!fin && !aborted) begin
          bv    = tx;
          ticks = 0;
          while (ticks < TICKS_PER_BIT && !aborted) begin
            if (reset) aborted = 1'b1;
            else begin
              if (tx !== bv || tx_done) glitch = 1'b1;
              if (sam_tick) ticks++;
              if (ticks < TICKS_PER_BIT) @(negedge clk);
            end
          end
          if (!aborted) begin
            if (nb < 12) bits[nb] = bv;
            nb++;
            @(negedge clk);
            if (reset) aborted = 1'b1;
            else if (tx_done) fin = 1'b1;
            else if (nb >= 13) begin
              glitch = 1'b1;
              fin    = 1'b1;
            end
          end
        end
        if (fin) begin
          act = {4'(nb), bits};
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame: unexpected frame got %h", act);
          end else begin
            exp_w = exp_q.pop_front();
            if (glitch || act !== exp_w) begin
              bad++;
              $display("FAIL frame: got %h glitch=%0b want %h", act, glitch, exp_w);
            end
          end
        end
      end
    end
  end

`ifdef UART_TX_FIFO_EN
  logic [7:0]   fifo_bytes [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [W-1:0] fifo_words [4] = '{16'hA244, 16'hA266, 16'hA288, 16'hA2AA};
`endif

  // Stimulus
  initial begin
    int t;
    reset    = 1'b0;
    tx_start = 1'b0;
    parity   = 2'b00;
    stop_bit = 1'b0;
    data_in  = 8'h00;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check1("rst_tx", tx, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", tx_done, 1'b0);
    check1("rst_ready", tx_ready, 1'b1);
    check("rst_state", 16'(dbg_state), 16'(IDLE));
    reset = 1'b0;

`ifdef UART_TX_FIFO_EN
    // One byte goes straight to the FSM, then 5 strobes while it is busy
    send(8'h11, 2'b00, 1'b0, 1'b1, 16'hA222);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check1("fifo_ready", tx_ready, (i < 4));
      data_in  = fifo_bytes[i];
      tx_start = 1'b1;
      if (i < 4) begin
        exp_q.push_back(fifo_words[i]);
        pushes++;
      end
    end
    @(posedge clk);
    #1 tx_start = 1'b0;
    repeat (5) wait_done();
`else
    // 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
    send(8'hA5, 2'b00, 1'b0, 1'b1, 16'hA34A);
    wait_done();
    // 0x07 even parity -> parity bit 1
    send(8'h07, 2'b10, 1'b0, 1'b1, 16'hB60E);
    wait_done();
    // 0x07 odd parity -> parity bit 0
    send(8'h07, 2'b01, 1'b0, 1'b1, 16'hB40E);
    wait_done();
    // 0x3C, mode 11 (none), two stops; mid-frame setting changes are ignored
    send(8'h3C, 2'b11, 1'b1, 1'b1, 16'hB678);
    parity   = 2'b10;
    stop_bit = 1'b0;
    wait_done();
    // 0x07 even parity then 32 stop ticks
    send(8'h07, 2'b10, 1'b1, 1'b1, 16'hCE0E);
    wait_done();
    // 0x81, with a strobe of 0x55 while busy that must be dropped
    send(8'h81, 2'b00, 1'b0, 1'b1, 16'hA302);
    repeat (40) @(negedge clk);
    check1("busy_ready", tx_ready, 1'b0);
    check1("busy_busy", busy, 1'b1);
    data_in  = 8'h55;
    tx_start = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    wait_done();
    // Byte issued in the tx_done cycle starts on the following clk
    check1("b2b_ready", tx_ready, 1'b1);
    data_in  = 8'hFF;
    parity   = 2'b00;
    stop_bit = 1'b0;
    tx_start = 1'b1;
    exp_q.push_back(16'hA3FE);
    pushes++;
    @(posedge clk);
    #1 tx_start = 1'b0;
    @(negedge clk);
    check1("b2b_start", tx, 1'b0);
    check("b2b_state", 16'(dbg_state), 16'(START));
    wait_done();
    // Reset during data bit 3 of 0x00
    send(8'h00, 2'b00, 1'b0, 1'b0, 16'h0000);
    t = 0;
    while (t < 72) begin
      @(negedge clk);
      if (sam_tick) t++;
    end
    check1("mid_tx", tx, 1'b0);
    check1("mid_busy", busy, 1'b1);
    check("mid_state", 16'(dbg_state), 16'(DATA));
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check1("arst_tx", tx, 1'b1);
    check1("arst_busy", busy, 1'b0);
    check1("arst_done", tx_done, 1'b0);
    check("arst_state", 16'(dbg_state), 16'(IDLE));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (700) @(negedge clk);
    check("arst_no_done", 16'(done_cnt), 16'(pushes));
    check1("arst_idle_tx", tx, 1'b1);
    // Recovery: 0x5A odd parity -> parity bit 1
    send(8'h5A, 2'b01, 1'b0, 1'b1, 16'hB6B4);
    wait_done();
`endif

    repeat (5) @(negedge clk);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    check("done_count", 16'(done_cnt), 16'(pushes));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries, used only with UART_TX_FIFO_EN; power of 2.
REQ-003 SHALL have port clk  input  1  system clock, all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sam_tick  input  1  16x-oversampling tick from the baud generator, one clk wide.
REQ-006 SHALL have port parity  input  2  parity mode: 00 or 11 none, 01 odd, 10 even.
REQ-007 SHALL have port stop_bit  input  1  stop bits: 0 one, 1 two.
REQ-008 SHALL have port tx_start  input  1  write strobe for data_in.
REQ-009 SHALL have port data_in  input  DATA_W  byte to send.
REQ-010 SHALL have port tx_ready  output  1  high when a tx_start is accepted this cycle.
REQ-011 SHALL have port tx  output  1  serial line, idle high.
REQ-012 SHALL have port busy  output  1  high while a frame is on the line.
REQ-013 SHALL have port tx_done  output  1  one-clk pulse at the end of each frame.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL accept a byte only when tx_start and tx_ready are high in the same cycle; tx_start while tx_ready is low SHALL be ignored.
REQ-016 SHALL, on acceptance in IDLE, latch data_in, parity and stop_bit, and enter START on the next clk; parity and stop_bit changes mid-frame SHALL have no effect.
REQ-017 SHALL count sam_tick with a 5-bit counter and hold every bit for exactly 16 ticks; clks without sam_tick SHALL not advance the counter.
REQ-018 SHALL drive tx = 0 in START, then go to DATA when the 16th tick is seen.
REQ-019 SHALL shift DATA_W bits out LSB first, one per 16 ticks, using a bit counter.
REQ-020 SHALL, after the last data bit, enter PARITY when parity is 01 or 10, else go straight to STOP.
REQ-021 SHALL compute the parity bit as follows: even = XOR of the data bits; odd = its inverse.
REQ-022 SHALL drive tx = 1 in STOP for 16 ticks when the latched stop_bit = 0, or 32 ticks when it is 1.
REQ-023 SHALL, on the final STOP tick, return to IDLE and pulse tx_done high for one clk on the next cycle.
REQ-024 SHALL drive tx = 1 in IDLE; tx SHALL be registered (glitch-free).
REQ-025 SHALL hold busy high in every state other than IDLE.
REQ-026 SHALL allow back-to-back frames: a byte accepted in the tx_done cycle starts START on the next clk, with no extra idle bit.

Reset
REQ-027 SHALL, on reset asserted asynchronously, force state = IDLE, tx = 1, busy = 0, tx_done = 0, and clear all counters and the shift register.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately with tx = 1 and produce no tx_done.
REQ-029 SHALL empty the FIFO on reset when UART_TX_FIFO_EN is defined.

Configuration
REQ-030 SHALL, with UART_TX_FIFO_EN defined, buffer accepted bytes in a FIFO_DEPTH FIFO; tx_ready = FIFO not full; the FSM pops the FIFO when in IDLE with the FIFO non-empty.
REQ-031 SHALL, with UART_TX_FIFO_EN defined, allow a push and a pop in the same cycle when the FIFO is full, with the count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-032 SHALL, without UART_TX_FIFO_EN, have no FIFO and set tx_ready = (state == IDLE).

Structure
REQ-033 SHALL take its state encoding (IDLE = 0 … STOP = 4) and the parity-mode constants PAR_NONE0/PAR_ODD/PAR_EVEN/PAR_NONE3 from a shared package uart_pkg, along with TICKS_PER_BIT = 16.
REQ-034 SHALL place the FIFO in the sub-module uart_tx_fifo, instantiated only under UART_TX_FIFO_EN.

Verification
REQ-035 SHALL cover: parity = 00, stop_bit = 0, send 0xA5 -> tx = 0, 1,0,1,0,0,1,0,1, 1 (10 bits x 16 ticks), then a single tx_done pulse.
REQ-036 SHALL cover: parity = 10, send 0x07 -> parity bit 1; parity = 01, send 0x07 -> parity bit 0; both frames 11 bits.
REQ-037 SHALL cover: stop_bit = 1 -> tx high for 32 ticks after the last data/parity bit before tx_done.
REQ-038 SHALL cover: tx_start while busy (no FIFO) -> byte dropped and tx unchanged; a byte issued in the tx_done cycle -> next start bit begins the following clk.
REQ-039 SHALL cover: reset asserted at data bit 3 -> tx = 1 and busy = 0 asynchronously, and no tx_done.
REQ-040 SHALL cover (FIFO build): push 5 bytes back-to-back with depth 4 -> tx_ready low after the 4th accept, and all accepted bytes transmitted in order.
